// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared pipeline encodings: access size, writeback source select and the
// memory-stage FSM state constants, plus small helpers for bus byte lanes.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    // Access size (mem_size)
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Writeback source select (wb_sel)
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_CMP  = 2'b11;

    // Memory-stage bus FSM states
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b10;

    // Byte enables of an aligned access within a 32-bit bus word.
    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] offset);
        case (size)
            SIZE_BYTE: byte_enables = 4'b0001 << offset;
            SIZE_HALF: byte_enables = 4'b0011 << {offset[1], 1'b0};
            default:   byte_enables = 4'b1111;
        endcase
    endfunction

    // Halfwords need an even address, anything wider a word-aligned one.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] offset);
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = offset[0];
            default:   misaligned = |offset;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// -----------------------------------------------------------------------------
// mem_load_align
// Combinational load-data alignment: moves the addressed byte/halfword of a
// bus word down to bit 0 and sign- or zero-extends it. Words pass unchanged.
// Ports:
//   rdata       in  XLEN  raw bus read data
//   offset      in  2     byte offset within the word (address[1:0])
//   size        in  2     access size (SIZE_BYTE/HALF/WORD)
//   is_unsigned in  1     zero-extend instead of sign-extend
//   data        out XLEN  aligned, extended load result
// -----------------------------------------------------------------------------
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;
    logic            sign_b;
    logic            sign_h;

    assign shifted = rdata >> {offset, 3'b000};
    assign sign_b  = shifted[7]  & ~is_unsigned;
    assign sign_h  = shifted[15] & ~is_unsigned;

    always_comb begin
        case (size)
            SIZE_BYTE: data = {{(XLEN-8){sign_b}},  shifted[7:0]};
            SIZE_HALF: data = {{(XLEN-16){sign_h}}, shifted[15:0]};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Pipeline memory stage: issues loads/stores on a req/gnt + rvalid data bus,
// stalls the pipeline until the access completes (or times out), and
// registers the MEM/WB slot.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   valid_i .. unsigned_i       EX/MEM slot (instruction, operands, controls)
//   stall_o                     hold EX/MEM and earlier stages
//   dbus_req/we/be/addr/wdata   bus request side (addr word-aligned)
//   dbus_gnt/rvalid/rdata       bus accept and read response
//   valid_o, wb_pc_o, rd_o,
//   rd_we_o, wb_data_o, exc_o   MEM/WB slot; exc_o[0] misaligned,
//                               exc_o[1] bus timeout
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [1:0]      mem_size_i,
    input  logic            mem_we_i,
    input  logic [1:0]      wb_sel_i,
    input  logic [4:0]      rd_i,
    input  logic            rd_we_i,
    input  logic            cmp_i,
    input  logic [XLEN-1:0] alu_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic            unsigned_i,
    output logic            stall_o,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [3:0]      dbus_be,
    output logic [XLEN-1:0] dbus_addr,
    output logic [XLEN-1:0] dbus_wdata,
    input  logic            dbus_gnt,
    input  logic            dbus_rvalid,
    input  logic [XLEN-1:0] dbus_rdata,
    output logic            valid_o,
    output logic [XLEN-1:0] wb_pc_o,
    output logic [4:0]      rd_o,
    output logic            rd_we_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [1:0]      exc_o
);

    localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_clr;
    logic             bus_req;
    logic             complete;
    logic             timeout;
    logic             is_store, is_load, is_access, is_misaligned, bus_access;
    logic [XLEN-1:0]  load_data;
    logic [XLEN-1:0]  wb_data_d;
    logic [1:0]       exc_d;
    logic             retire;

    // Access decode: a store wins over the load encoding.
    assign is_store      = valid_i & mem_we_i;
    assign is_load       = valid_i & ~mem_we_i & (wb_sel_i == WB_LOAD);
    assign is_access     = is_store | is_load;
    assign is_misaligned = is_access & misaligned(mem_size_i, alu_i[1:0]);
    assign bus_access    = is_access & ~is_misaligned;

    assign timeout = (state_q != ST_IDLE) && (cnt_q == CNT_W'(RSP_TIMEOUT));

    // Bus FSM. In IDLE the request goes out combinationally so a zero-wait
    // store retires without a stall; address/data come straight from the
    // EX/MEM slot, which the stall keeps stable while the request waits.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would infer a latch.
        state_d  = state_q;
        cnt_clr  = 1'b0;
        bus_req  = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                complete = ~bus_access;
                if (bus_access) begin
                    bus_req = 1'b1;
                    if (dbus_gnt && is_store) begin
                        complete = 1'b1;
                    end else begin
                        state_d = dbus_gnt ? ST_WAIT : ST_REQ;
                        cnt_clr = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (timeout) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    bus_req = 1'b1;
                    if (dbus_gnt) begin
                        if (is_store) begin
                            complete = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_clr = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                // A timeout wins over a response arriving in the same cycle.
                if (timeout || dbus_rvalid) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The request must read low for the whole reset pulse, even while the
    // slot still presents an access to the (already reset) IDLE state.
    assign dbus_req = bus_req & rst_n;
    assign stall_o  = valid_i & ~complete;
    assign retire   = valid_i & complete;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (state_q != ST_IDLE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Bus request payload
    assign dbus_we   = is_store;
    assign dbus_addr = {alu_i[XLEN-1:2], 2'b00};
    assign dbus_be   = byte_enables(mem_size_i, alu_i[1:0]);

    always_comb begin
        case (mem_size_i)
            SIZE_BYTE: dbus_wdata = {(XLEN/8){store_data_i[7:0]}};
            SIZE_HALF: dbus_wdata = {(XLEN/16){store_data_i[15:0]}};
            default:   dbus_wdata = store_data_i;
        endcase
    end

    mem_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata       (dbus_rdata),
        .offset      (alu_i[1:0]),
        .size        (mem_size_i),
        .is_unsigned (unsigned_i),
        .data        (load_data)
    );

    always_comb begin
        case (wb_sel_i)
            WB_ALU:  wb_data_d = alu_i;
            WB_LOAD: wb_data_d = load_data;
            WB_PC4:  wb_data_d = pc_i + XLEN'(4);
            default: wb_data_d = {{(XLEN-1){1'b0}}, cmp_i};
        endcase
    end

    assign exc_d = {timeout, is_misaligned};

    // MEM/WB slot: payload holds between retires, qualifiers drop to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o   <= 1'b0;
            wb_pc_o   <= '0;
            rd_o      <= '0;
            rd_we_o   <= 1'b0;
            wb_data_o <= '0;
            exc_o     <= '0;
        end else if (retire) begin
            valid_o   <= 1'b1;
            wb_pc_o   <= pc_i;
            rd_o      <= rd_i;
            rd_we_o   <= rd_we_i & ~|exc_d;
            wb_data_o <= wb_data_d;
            exc_o     <= exc_d;
        end else begin
            valid_o   <= 1'b0;
            rd_we_o   <= 1'b0;
            exc_o     <= '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage (RSP_TIMEOUT = 4). A reference model
// derives stall count, exception and writeback value of each instruction
// from its gnt/rvalid delays with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int XLEN = 32;
    localparam int TO   = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_i;
    logic [XLEN-1:0] pc_i;
    logic [1:0]      mem_size_i;
    logic            mem_we_i;
    logic [1:0]      wb_sel_i;
    logic [4:0]      rd_i;
    logic            rd_we_i;
    logic            cmp_i;
    logic [XLEN-1:0] alu_i;
    logic [XLEN-1:0] store_data_i;
    logic            unsigned_i;
    logic            stall_o;
    logic            dbus_req;
    logic            dbus_we;
    logic [3:0]      dbus_be;
    logic [XLEN-1:0] dbus_addr;
    logic [XLEN-1:0] dbus_wdata;
    logic            dbus_gnt;
    logic            dbus_rvalid;
    logic [XLEN-1:0] dbus_rdata;
    logic            valid_o;
    logic [XLEN-1:0] wb_pc_o;
    logic [4:0]      rd_o;
    logic            rd_we_o;
    logic [XLEN-1:0] wb_data_o;
    logic [1:0]      exc_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage #(.XLEN(XLEN), .RSP_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .pc_i(pc_i),
        .mem_size_i(mem_size_i), .mem_we_i(mem_we_i), .wb_sel_i(wb_sel_i),
        .rd_i(rd_i), .rd_we_i(rd_we_i), .cmp_i(cmp_i), .alu_i(alu_i),
        .store_data_i(store_data_i), .unsigned_i(unsigned_i),
        .stall_o(stall_o), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_be(dbus_be), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
        .dbus_rdata(dbus_rdata), .valid_o(valid_o), .wb_pc_o(wb_pc_o),
        .rd_o(rd_o), .rd_we_o(rd_we_o), .wb_data_o(wb_data_o), .exc_o(exc_o)
    );

    always #5 clk = ~clk;

    // Reference: extract and extend the addressed lane of a read word.
    function automatic logic [31:0] ref_load(input logic [31:0] rdata,
                                             input logic [31:0] addr,
                                             input logic [1:0] size,
                                             input logic uns);
        int off;
        logic [31:0] lane;
        off  = int'(addr[1:0]);
        lane = rdata >> (8 * off);
        if (size == 2'd0) return uns ? (lane & 32'hFF) : 32'($signed(lane[7:0]));
        if (size == 2'd1) return uns ? (lane & 32'hFFFF) : 32'($signed(lane[15:0]));
        return rdata;
    endfunction

    // Execute one instruction. g: cycle (from issue) at which gnt is given,
    // r: cycles waited in the response phase before rvalid, spur: pulse rvalid
    // while no response may be accepted. Starts and ends at posedge+1.
    task automatic exec(input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [1:0] size,
                        input logic [1:0] sel, input logic we, input logic uns,
                        input logic rdwe, input logic cmp, input logic [4:0] rd,
                        input int g, input int r, input bit spur,
                        input logic [31:0] rdata,
                        output int stalls, output logic [31:0] wbd,
                        output logic [1:0] exc);
        bit is_store, is_load, mis, bus, exp_req;
        int exp_stalls, c;
        logic [1:0]  exp_exc;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_wbd;

        is_store = we;
        is_load  = !we && sel == 2'd1;
        mis      = (is_store || is_load) &&
                   ((size == 2'd1 && alu[0]) || (size == 2'd2 && alu[1:0] != 2'd0));
        bus      = (is_store || is_load) && !mis;

        if (!bus) begin
            exp_stalls = 0;             exp_exc = mis ? 2'b01 : 2'b00;
        end else if (g > TO) begin
            exp_stalls = TO + 1;        exp_exc = 2'b10;
        end else if (is_store) begin
            exp_stalls = g;             exp_exc = 2'b00;
        end else if (r + 1 <= TO) begin
            exp_stalls = g + 1 + r;     exp_exc = 2'b00;
        end else begin
            exp_stalls = g + TO + 1;    exp_exc = 2'b10;
        end

        case (size)
            2'd0:    begin exp_be = 4'b0001 << alu[1:0];   exp_wdata = {4{sd[7:0]}};  end
            2'd1:    begin exp_be = alu[1] ? 4'b1100 : 4'b0011; exp_wdata = {2{sd[15:0]}}; end
            default: begin exp_be = 4'b1111;               exp_wdata = sd;            end
        endcase

        case (sel)
            2'd0:    exp_wbd = alu;
            2'd1:    exp_wbd = ref_load(rdata, alu, size, uns);
            2'd2:    exp_wbd = pc + 32'd4;
            default: exp_wbd = {31'd0, cmp};
        endcase

        valid_i = 1'b1; pc_i = pc; alu_i = alu; store_data_i = sd;
        mem_size_i = size; wb_sel_i = sel; mem_we_i = we; unsigned_i = uns;
        rd_we_i = rdwe; cmp_i = cmp; rd_i = rd; dbus_rdata = rdata;

        c = 0;
        forever begin
            dbus_gnt    = bus && (c == g);
            dbus_rvalid = (bus && is_load && c == g + 1 + r) || (spur && c <= g);
            @(negedge clk);
            exp_req = bus && c <= g && c <= TO;
            n_tests++;
            if (dbus_req !== exp_req) begin
                n_fail++;
                $display("FAIL dbus_req cyc%0d: got %b expected %b", c, dbus_req, exp_req);
            end
            if (exp_req && dbus_req === 1'b1) begin
                n_tests++;
                if (dbus_addr !== {alu[31:2], 2'b00} || dbus_be !== exp_be ||
                    dbus_we !== we || (we && dbus_wdata !== exp_wdata)) begin
                    n_fail++;
                    $display("FAIL bus_payload cyc%0d: got addr %h be %b we %b wdata %h expected addr %h be %b we %b wdata %h",
                             c, dbus_addr, dbus_be, dbus_we, dbus_wdata,
                             {alu[31:2], 2'b00}, exp_be, we, exp_wdata);
                end
            end
            if (stall_o !== 1'b1) break;
            c++;
            if (c > 30) begin
                n_tests++; n_fail++;
                $display("FAIL stall_bound: got stall beyond 30 cycles expected %0d", exp_stalls);
                break;
            end
            @(posedge clk); #1;
        end
        stalls = c;

        @(posedge clk); #1;
        valid_i = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        wbd = wb_data_o; exc = exc_o;

        n_tests++;
        if (stalls !== exp_stalls) begin
            n_fail++; $display("FAIL stall_count: got %0d expected %0d", stalls, exp_stalls);
        end
        n_tests++;
        if (valid_o !== 1'b1 || exc_o !== exp_exc || rd_o !== rd || wb_pc_o !== pc ||
            rd_we_o !== (rdwe && exp_exc == 2'b00)) begin
            n_fail++;
            $display("FAIL wb_slot: got v%b exc%b rd%0d pc%h we%b expected v1 exc%b rd%0d pc%h we%b",
                     valid_o, exc_o, rd_o, wb_pc_o, rd_we_o, exp_exc, rd, pc,
                     rdwe && exp_exc == 2'b00);
        end
        if (exp_exc == 2'b00 || sel != 2'd1) begin
            n_tests++;
            if (wb_data_o !== exp_wbd) begin
                n_fail++; $display("FAIL wb_data: got %h expected %h", wb_data_o, exp_wbd);
            end
        end
    endtask

    task automatic test_reset;
        // Reset held with an aligned load presented: no request may escape.
        valid_i = 1'b1; mem_we_i = 1'b0; wb_sel_i = 2'd1; mem_size_i = 2'd2;
        alu_i = 32'h100;
        #1;
        n_tests++;
        if (dbus_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b expected 0", dbus_req);
        end
        @(posedge clk); #1;
        n_tests++;
        if (valid_o !== 1'b0 || rd_we_o !== 1'b0 || exc_o !== 2'b00 || rd_o !== 5'd0 ||
            wb_pc_o !== 32'd0 || wb_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v%b we%b exc%b rd%0d pc%h data%h expected all zero",
                     valid_o, rd_we_o, exc_o, rd_o, wb_pc_o, wb_data_o);
        end
        valid_i = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_valid: got %b expected 0", valid_o);
        end
    endtask

    task automatic test_lb_signed;
        int s; logic [31:0] d; logic [1:0] e;
        exec(32'h400, 32'h1003, 32'h0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3,
             0, 0, 1'b0, 32'h80FF_0000, s, d, e);
        n_tests++;
        if (d !== 32'hFFFF_FF80 || s != 1) begin
            n_fail++; $display("FAIL lb_signed: got data %h stalls %0d expected ffffff80 1", d, s);
        end
    endtask

    task automatic test_sh_zero_wait;
        int s; logic [31:0] d; logic [1:0] e;
        exec(32'h404, 32'h2002, 32'h1234_ABCD, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,
             0, 0, 1'b0, 32'h0, s, d, e);
        n_tests++;
        if (s != 0 || e !== 2'b00) begin
            n_fail++; $display("FAIL sh_zero_wait: got stalls %0d exc %b expected 0 00", s, e);
        end
    endtask

    task automatic test_lw_misaligned;
        int s; logic [31:0] d; logic [1:0] e;
        exec(32'h408, 32'h3001, 32'h0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7,
             0, 0, 1'b0, 32'hDEAD_BEEF, s, d, e);
        n_tests++;
        if (e !== 2'b01 || s != 0 || rd_we_o !== 1'b0) begin
            n_fail++; $display("FAIL lw_misaligned: got exc %b stalls %0d we %b expected 01 0 0", e, s, rd_we_o);
        end
    endtask

    task automatic test_lw_slow;
        int s; logic [31:0] d; logic [1:0] e;
        exec(32'h40C, 32'h3000, 32'h0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9,
             3, 2, 1'b0, 32'hCAFE_F00D, s, d, e);
        n_tests++;
        if (s != 6 || d !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL lw_slow: got stalls %0d data %h expected 6 cafef00d", s, d);
        end
    endtask

    task automatic test_timeout;
        int s; logic [31:0] d; logic [1:0] e;
        exec(32'h410, 32'h3004, 32'h0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4,
             99, 0, 1'b0, 32'h0, s, d, e);
        n_tests++;
        if (e !== 2'b10 || s != TO + 1 || rd_we_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout: got exc %b stalls %0d we %b expected 10 %0d 0", e, s, rd_we_o, TO + 1);
        end
    endtask

    task automatic test_reset_in_wait;
        int s; logic [31:0] d; logic [1:0] e;
        valid_i = 1'b1; mem_we_i = 1'b0; wb_sel_i = 2'd1; mem_size_i = 2'd2;
        alu_i = 32'h500; rd_we_i = 1'b1; dbus_gnt = 1'b1;
        @(posedge clk); #1;             // granted: now waiting for the response
        dbus_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (dbus_req !== 1'b0 || valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_wait: got req %b valid %b expected 0 0", dbus_req, valid_o);
        end
        valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dbus_rvalid = 1'b1; dbus_rdata = 32'h1111_2222;   // late response
        @(posedge clk); #1;
        dbus_rvalid = 1'b0;
        n_tests++;
        if (valid_o !== 1'b0 || rd_we_o !== 1'b0) begin
            n_fail++; $display("FAIL late_rvalid: got valid %b we %b expected 0 0", valid_o, rd_we_o);
        end
        // The stage must be back in IDLE and ignore a stray response there.
        exec(32'h414, 32'h504, 32'h0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5,
             1, 1, 1'b1, 32'h3333_4444, s, d, e);
    endtask

    task automatic test_passthrough;
        int s; logic [31:0] d; logic [1:0] e;
        exec(32'hFFFF_FFFC, 32'h55, 32'h0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1,
             0, 0, 1'b0, 32'h0, s, d, e);
        n_tests++;
        if (d !== 32'h0 || s != 0) begin
            n_fail++; $display("FAIL pc4_wrap: got %h stalls %0d expected 00000000 0", d, s);
        end
        exec(32'h420, 32'h55, 32'h0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2,
             0, 0, 1'b0, 32'h0, s, d, e);
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL cmp_wb: got %h expected 00000001", d);
        end
        @(posedge clk); #1;             // bubble
        n_tests++;
        if (valid_o !== 1'b0 || rd_we_o !== 1'b0 || exc_o !== 2'b00) begin
            n_fail++; $display("FAIL bubble: got v%b we%b exc%b expected 0 0 00", valid_o, rd_we_o, exc_o);
        end
    endtask

    task automatic test_random;
        int s; logic [31:0] d; logic [1:0] e;
        for (int i = 0; i < 80; i++) begin
            exec($urandom, $urandom, $urandom, 2'($urandom_range(0, 2)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                 int'($urandom_range(0, TO + 1)), int'($urandom_range(0, TO)),
                 1'($urandom), $urandom, s, d, e);
        end
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; pc_i = '0; mem_size_i = '0; mem_we_i = 1'b0;
        wb_sel_i = '0; rd_i = '0; rd_we_i = 1'b0; cmp_i = 1'b0; alu_i = '0;
        store_data_i = '0; unsigned_i = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        dbus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_lb_signed;
        test_sh_zero_wait;
        test_lw_misaligned;
        test_lw_slow;
        test_timeout;
        test_reset_in_wait;
        test_passthrough;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
